// File: rtl/uart_bus_sequencer_pkg.sv
// uart_bus_sequencer_pkg: sequencer state codes, UART register map and control bit positions
package uart_bus_sequencer_pkg;
  typedef logic [2:0] sq_state_t;
  localparam sq_state_t SQIdle         = 3'd0;
  localparam sq_state_t SQStatusAddr   = 3'd1;
  localparam sq_state_t SQStatusSample = 3'd2;
  localparam sq_state_t SQRxAddr       = 3'd3;
  localparam sq_state_t SQRxSample     = 3'd4;
  localparam sq_state_t SQTxWrite      = 3'd5;
  localparam sq_state_t SQSettle       = 3'd6;
  localparam logic [2:0] UA_ADDR_CTRL = 3'd0;
  localparam logic [2:0] UA_ADDR_RX   = 3'd1;
  localparam logic [2:0] UA_ADDR_TX   = 3'd2;
  localparam int CTL_TX_BUSY = 0;
  localparam int CTL_RX_AVAL = 1;
endpackage

// File: rtl/uart_bus_sequencer_rr_arbiter.sv
// uart_bus_sequencer_rr_arbiter: combinational pick of the first request at or after ptr
module uart_bus_sequencer_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic [IW:0] s;
  // scan farthest-first so the nearest index to ptr overwrites and wins
  always_comb begin
    grant = '0;
    idx = '0;
    s = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (IW+1)'(k);
      if (s >= (IW+1)'(NUM_REQ)) s = s - (IW+1)'(NUM_REQ);
      if (req[s[IW-1:0]]) begin
        grant = '0;
        grant[s[IW-1:0]] = 1'b1;
        idx = s[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/uart_bus_sequencer.sv
// uart_bus_sequencer: polls the UART, drains RX bytes and shares TX among requesters round-robin
module uart_bus_sequencer
  import uart_bus_sequencer_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     tx_req,
  input  logic [8*NUM_REQ-1:0]   tx_data,
  output logic [NUM_REQ-1:0]     tx_ack,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic                   uart_cs,
  output logic                   uart_wr,
  output logic                   uart_rd_strobe,
  output logic [2:0]             uart_addr,
  output logic [7:0]             uart_wdata,
  input  logic [7:0]             uart_rdata,
  output logic                   busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  sq_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, arb_idx;
  logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d, arb_oh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;

  uart_bus_sequencer_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req(tx_req),
    .ptr(ptr_q),
    .grant(arb_oh),
    .idx(arb_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    gnt_oh_d = gnt_oh_q;
    cnt_d = '0;
    rx_valid_d = (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
    rx_data_d = rx_data_q;
    case (state_q)
      SQIdle:         state_d = SQStatusAddr;
      SQStatusAddr:   state_d = SQStatusSample;
      SQStatusSample: begin
        if (uart_rdata[CTL_RX_AVAL] && !rx_valid_q) state_d = SQRxAddr;
        else if (!uart_rdata[CTL_TX_BUSY] && |tx_req) begin
          state_d = SQTxWrite;
          grant_d = arb_idx;
          gnt_oh_d = arb_oh;
        end
        // a status read also needs settle time before the next poll
        else state_d = SQSettle;
      end
      SQRxAddr:       state_d = SQRxSample;
      SQRxSample: begin
        rx_data_d = uart_rdata;
        rx_valid_d = 1'b1;
        state_d = SQSettle;
      end
      SQTxWrite: begin
        ptr_d = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = SQSettle;
      end
      SQSettle: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE_CYCLES - 1)) ? SQIdle : SQSettle;
      end
      default:        state_d = SQIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= SQIdle;
      ptr_q <= '0;
      grant_q <= '0;
      gnt_oh_q <= '0;
      cnt_q <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      gnt_oh_q <= gnt_oh_d;
      cnt_q <= cnt_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q <= rx_data_d;
    end
  end

  // bus outputs decode straight from state so an async reset clears them at once
  assign busy = state_q != SQIdle;
  assign uart_cs = (state_q == SQIdle) || (state_q == SQSettle);
  assign uart_wr = state_q != SQTxWrite;
  assign uart_rd_strobe = (state_q == SQStatusAddr) || (state_q == SQRxAddr);
  assign uart_addr = (state_q == SQRxAddr || state_q == SQRxSample) ? UA_ADDR_RX :
                     (state_q == SQTxWrite) ? UA_ADDR_TX : UA_ADDR_CTRL;
  assign uart_wdata = (state_q == SQTxWrite) ? tx_data[{grant_q, 3'b000} +: 8] : 8'h00;
  assign tx_ack = (state_q == SQTxWrite) ? gnt_oh_q : '0;
  assign rx_valid = rx_valid_q;
  assign rx_data = rx_data_q;
endmodule

// File: tb/tb_uart_bus_sequencer.sv
// tb_uart_bus_sequencer: table-driven poll transactions plus backpressure and async reset sequences
module tb_uart_bus_sequencer;
  import uart_bus_sequencer_pkg::*;
  localparam logic [63:0] RST_OUTS = 64'h6000;
  logic clock = 1'b0;
  logic reset;
  logic [3:0] tx_req, tx_ack;
  logic [31:0] tx_data;
  logic rx_valid, rx_ready, uart_cs, uart_wr, uart_rd_strobe, busy;
  logic [7:0] rx_data, uart_wdata, uart_rdata, status, rx_byte;
  logic [2:0] uart_addr;
  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data;
    logic [7:0]  st;
    logic [7:0]  rxb;
    logic        ewr;
    logic [7:0]  ewd;
    logic [3:0]  eack;
    logic        erx;
    logic [3:0]  elen;
    logic [7:0]  erxd;
  } vec_t;
  vec_t v[13];

  always #5 clock = ~clock;

  uart_bus_sequencer #(.NUM_REQ(4), .SETTLE_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .tx_req(tx_req), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready), .uart_cs(uart_cs),
    .uart_wr(uart_wr), .uart_rd_strobe(uart_rd_strobe), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata), .busy(busy)
  );

  assign uart_rdata = (uart_addr == UA_ADDR_RX) ? rx_byte : (uart_addr == UA_ADDR_CTRL) ? status : 8'h00;

  function automatic logic [7:0] st(input logic rx, input logic tb);
    logic [7:0] s;
    s = '0;
    s[CTL_RX_AVAL] = rx;
    s[CTL_TX_BUSY] = tb;
    return s;
  endfunction

  function automatic logic [63:0] outs();
    return {36'h0, tx_ack, rx_valid, rx_data, uart_cs, uart_wr, uart_rd_strobe, uart_addr, uart_wdata, busy};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic poll(output logic wr, output logic [7:0] wd, output logic [3:0] ack, output logic rx, output int len);
    logic found;
    wr = 0; wd = 0; ack = 0; rx = 0; len = 0; found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      found = uart_rd_strobe && uart_addr == UA_ADDR_CTRL;
    end
    check("poll_start", 64'(found), 64'd1);
    if (!found) return;
    check("poll_cs", 64'(uart_cs), 64'd0);
    len = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (!busy) break;
      len++;
      if (!uart_wr) begin
        wr = 1; wd = uart_wdata; ack = tx_ack;
      end
      if (uart_rd_strobe && uart_addr == UA_ADDR_RX) rx = 1;
      check("ack_only_on_write",
            64'(tx_ack == 4'h0 || (!uart_wr && !uart_cs && uart_addr == UA_ADDR_TX && $onehot(tx_ack))), 64'd1);
    end
  endtask

  initial begin
    logic wr, rx, found;
    logic [7:0] wd;
    logic [3:0] ack;
    int len;
    reset = 1'b0; tx_req = '0; tx_data = '0; rx_ready = 1'b1; status = '0; rx_byte = '0;
    v[0]  = '{4'h0, 32'h0,        st(0, 0), 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 4'd4, 8'h00};
    v[1]  = '{4'hf, 32'h13121110, st(0, 0), 8'h00, 1'b1, 8'h10, 4'h1, 1'b0, 4'd5, 8'h00};
    v[2]  = '{4'hf, 32'h13121110, st(0, 0), 8'h00, 1'b1, 8'h11, 4'h2, 1'b0, 4'd5, 8'h00};
    v[3]  = '{4'hf, 32'h13121110, st(0, 0), 8'h00, 1'b1, 8'h12, 4'h4, 1'b0, 4'd5, 8'h00};
    v[4]  = '{4'hf, 32'h13121110, st(0, 0), 8'h00, 1'b1, 8'h13, 4'h8, 1'b0, 4'd5, 8'h00};
    v[5]  = '{4'hf, 32'h13121110, st(0, 0), 8'h00, 1'b1, 8'h10, 4'h1, 1'b0, 4'd5, 8'h00};
    v[6]  = '{4'hf, 32'h13121110, st(0, 1), 8'h00, 1'b0, 8'h00, 4'h0, 1'b0, 4'd4, 8'h00};
    v[7]  = '{4'h1, 32'h00000041, st(0, 0), 8'h00, 1'b1, 8'h41, 4'h1, 1'b0, 4'd5, 8'h00};
    v[8]  = '{4'h2, 32'h00002200, st(1, 0), 8'h5a, 1'b0, 8'h00, 4'h0, 1'b1, 4'd6, 8'h5a};
    v[9]  = '{4'h2, 32'h00002200, st(0, 0), 8'h00, 1'b1, 8'h22, 4'h2, 1'b0, 4'd5, 8'h00};
    v[10] = '{4'h5, 32'h00330044, st(0, 0), 8'h00, 1'b1, 8'h33, 4'h4, 1'b0, 4'd5, 8'h00};
    v[11] = '{4'h5, 32'h00330044, st(0, 0), 8'h00, 1'b1, 8'h44, 4'h1, 1'b0, 4'd5, 8'h00};
    v[12] = '{4'h0, 32'h0,        st(1, 1), 8'h66, 1'b0, 8'h00, 4'h0, 1'b1, 4'd6, 8'h66};
    repeat (3) @(negedge clock);
    check("reset_outputs", outs(), RST_OUTS);
    reset = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tx_req = v[i].req; tx_data = v[i].data; status = v[i].st; rx_byte = v[i].rxb;
      poll(wr, wd, ack, rx, len);
      check($sformatf("v%0d_wr", i), 64'(wr), 64'(v[i].ewr));
      check($sformatf("v%0d_wdata", i), 64'(wd), 64'(v[i].ewd));
      check($sformatf("v%0d_ack", i), 64'(ack), 64'(v[i].eack));
      check($sformatf("v%0d_rx_read", i), 64'(rx), 64'(v[i].erx));
      check($sformatf("v%0d_busy_len", i), 64'(len), 64'(v[i].elen));
      if (v[i].erx) check($sformatf("v%0d_rx_data", i), 64'(rx_data), 64'(v[i].erxd));
    end
    rx_ready = 1'b0; tx_req = '0; status = st(1, 0); rx_byte = 8'h5a;
    poll(wr, wd, ack, rx, len);
    check("bp_first_read", 64'(rx), 64'd1);
    check("bp_rx_valid_held", 64'(rx_valid), 64'd1);
    check("bp_rx_data", 64'(rx_data), 64'h5a);
    rx_byte = 8'ha5; tx_req = 4'b0100; tx_data = 32'h00770000;
    poll(wr, wd, ack, rx, len);
    check("bp_no_read", 64'(rx), 64'd0);
    check("bp_tx_wdata", 64'(wd), 64'h77);
    check("bp_tx_ack", 64'(ack), 64'h4);
    check("bp_rx_data_kept", 64'(rx_data), 64'h5a);
    tx_req = '0; rx_ready = 1'b1;
    @(posedge clock);
    #1 check("bp_rx_valid_cleared", 64'(rx_valid), 64'd0);
    poll(wr, wd, ack, rx, len);
    check("bp_second_read", 64'(rx), 64'd1);
    check("bp_second_data", 64'(rx_data), 64'ha5);
    tx_req = 4'b0001; tx_data = 32'hd3d2d1d0; status = st(0, 0);
    found = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      found = !uart_wr;
    end
    check("reach_tx_write", 64'(found), 64'd1);
    check("pre_reset_wdata", 64'(uart_wdata), 64'hd0);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", outs(), RST_OUTS);
    @(negedge clock);
    check("reset_held_outputs", outs(), RST_OUTS);
    reset = 1'b1; tx_req = '0;
    poll(wr, wd, ack, rx, len);
    check("post_reset_no_ack", 64'(ack), 64'h0);
    check("post_reset_no_wr", 64'(wr), 64'd0);
    tx_req = 4'b1001;
    poll(wr, wd, ack, rx, len);
    check("post_reset_ptr_wdata", 64'(wd), 64'hd0);
    check("post_reset_ptr_ack", 64'(ack), 64'h1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
